hart_bus_arbiter: RTL
=====================

HART_BUS_ARBITER -- requirements
Module: hart_bus_arbiter

Interface
REQ-001 Parameter: NUM_HARTS, 2, number of requesting harts (1..8).
REQ-002 Parameter: LOCK_MAX, 16, max consecutive locked grants to one hart (used only under HART_BUS_LOCK_EN).
REQ-003 Port: CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: nRST  in  1  reset, synchronous, active-low.
REQ-005 Port: req_ren  in  NUM_HARTS  per-hart read request.
REQ-006 Port: req_wen  in  NUM_HARTS  per-hart write request.
REQ-007 Port: req_addr  in  NUM_HARTS*32  per-hart address.
REQ-008 Port: req_wdata  in  NUM_HARTS*32  per-hart write data.
REQ-009 Port: req_byte_en  in  NUM_HARTS*4  per-hart byte enables.
REQ-010 Port: req_abort  in  NUM_HARTS  per-hart abort; masks that hart from arbitration.
REQ-011 Port: req_lock  in  NUM_HARTS  per-hart lock hint (present only under HART_BUS_LOCK_EN).
REQ-012 Port: req_busy  out  NUM_HARTS  per-hart busy; low only on the granted hart's completion cycle.
REQ-013 Port: req_rdata  out  32  read data broadcast to all harts; valid when that hart's req_busy is low.
REQ-014 Port: bus_ren / bus_wen  out  1 each  downstream read/write strobe.
REQ-015 Port: bus_addr / bus_wdata  out  32 each;  bus_byte_en  out  4  downstream request fields.
REQ-016 Port: bus_rdata  in  32;  bus_busy  in  1  downstream response; bus_busy low = transfer complete.
REQ-017 Port: grant_id  out  max(1,$clog2(NUM_HARTS))  index of current/last granted hart.

Function
REQ-018 FSM states IDLE and BUSY only.
REQ-019 Hart i is eligible in IDLE when (req_ren[i] | req_wen[i]) & ~req_abort[i].
REQ-020 IDLE: if any hart eligible, register grant = first eligible hart searching from (rr_ptr) upward, wrapping modulo NUM_HARTS; latch the winner's request fields; go BUSY next edge.
REQ-021 BUSY: bus_* outputs driven from latched fields; request fields from harts ignored.
REQ-022 req_wen and req_ren both high: issue as write, bus_ren low.
REQ-023 BUSY with bus_busy low: req_busy[grant]=0 and req_rdata=bus_rdata combinationally that cycle; next edge go IDLE, rr_ptr = (grant+1) mod NUM_HARTS.
REQ-024 Latency: request seen in IDLE at cycle N -> bus strobe at N+1; minimum completion (bus_busy low at N+1) -> req_busy low at N+1; next arbitration at N+2.
REQ-025 Issued transfer always completes; req_abort asserted in BUSY does not cancel it, only blocks re-arbitration.
REQ-026 IDLE and BUSY-with-bus_busy-high: all req_busy bits high; bus_ren/bus_wen low in IDLE.
REQ-027 No eligible harts in IDLE: stay IDLE, rr_ptr unchanged.
REQ-028 NUM_HARTS=1: hart 0 always wins; rr_ptr stays 0.
REQ-029 grant_id holds last grant while IDLE.

Reset
REQ-030 nRST low at an edge: state=IDLE, rr_ptr=0, grant_id=0, latched fields=0, lock count=0, regardless of current state.
REQ-031 Reset mid-BUSY: bus_ren/bus_wen low from the following cycle; in-flight transfer abandoned, no req_busy low pulse issued.
REQ-032 During/after reset: req_busy all high, req_rdata=0 until first completion.

Configuration
REQ-033 Macro HART_BUS_LOCK_EN defined: on completion, if req_lock[grant] high and lock count < LOCK_MAX-1, rr_ptr = grant and count increments; else rr_ptr rotates and count clears.
REQ-034 Lock count clears on any completion where rr_ptr rotates.
REQ-035 HART_BUS_LOCK_EN undefined: req_lock port absent, pure round-robin per REQ-023.

Verification
REQ-036 NUM_HARTS=2, both ren at 0x80000000/0x80000010 same cycle after reset, bus_busy low 1 cycle after strobe -> hart 0 served first, then hart 1; grant_id 0 then 1.
REQ-037 Hart 1 wen+ren, wdata 0xDEADBEEF, byte_en 0xF -> bus_wen=1, bus_ren=0, bus_wdata 0xDEADBEEF.
REQ-038 bus_busy held high 5 cycles -> req_busy[grant] high 5 cycles, low exactly one cycle with req_rdata=bus_rdata (0x12345678).
REQ-039 req_abort[0] high with both requesting -> hart 1 granted; abort during BUSY -> transfer still completes.
REQ-040 nRST low during BUSY -> next cycle IDLE, bus strobes low, rr_ptr=0, no req_busy low pulse.
REQ-041 HART_BUS_LOCK_EN, LOCK_MAX=4, hart 0 lock+ren continuously, hart 1 ren -> hart 0 gets 4 grants, then hart 1.

Source files
------------

// File: rtl/hart_bus_arbiter.sv
// Round-robin arbiter muxing NUM_HARTS request ports onto one bus; optional lock via HART_BUS_LOCK_EN.
// Latency: request seen in IDLE -> bus strobe next cycle; completion reported combinationally from bus_busy.
// Backpressure: bus_busy high stalls the granted hart (req_busy high); other harts wait in arbitration.
module hart_bus_arbiter #(
    parameter int NUM_HARTS = 2,
    parameter int LOCK_MAX  = 16
) (
    input  logic                                         CLK,
    input  logic                                         nRST,
    input  logic [NUM_HARTS-1:0]                         req_ren,
    input  logic [NUM_HARTS-1:0]                         req_wen,
    input  logic [NUM_HARTS*32-1:0]                      req_addr,
    input  logic [NUM_HARTS*32-1:0]                      req_wdata,
    input  logic [NUM_HARTS*4-1:0]                       req_byte_en,
    input  logic [NUM_HARTS-1:0]                         req_abort,
`ifdef HART_BUS_LOCK_EN
    input  logic [NUM_HARTS-1:0]                         req_lock,
`endif
    output logic [NUM_HARTS-1:0]                         req_busy,
    output logic [31:0]                                  req_rdata,
    output logic                                         bus_ren,
    output logic                                         bus_wen,
    output logic [31:0]                                  bus_addr,
    output logic [31:0]                                  bus_wdata,
    output logic [3:0]                                   bus_byte_en,
    input  logic [31:0]                                  bus_rdata,
    input  logic                                         bus_busy,
    output logic [(NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1)-1:0] grant_id
);

    localparam int GW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    if (NUM_HARTS < 1 || NUM_HARTS > 8 || LOCK_MAX < 1) begin : g_bad_cfg
        $error("hart_bus_arbiter: unsupported NUM_HARTS or LOCK_MAX");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            lat_ren_q, lat_ren_d;
    logic            lat_wen_q, lat_wen_d;
    logic [31:0]     lat_addr_q, lat_addr_d;
    logic [31:0]     lat_wdata_q, lat_wdata_d;
    logic [3:0]      lat_be_q, lat_be_d;
    logic [31:0]     rdata_q, rdata_d;

`ifdef HART_BUS_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
`endif

    logic [NUM_HARTS-1:0] eligible;
    logic                 win_vld;
    logic [GW-1:0]        win_idx;
    logic [GW-1:0]        rot_ptr;
    logic                 done;

    assign eligible = (req_ren | req_wen) & ~req_abort;

    // Completion is suppressed while reset is asserted so an abandoned transfer never pulses req_busy.
    assign done = (state_q == BUSY) && !bus_busy && nRST;

    // First eligible hart at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_HARTS) begin
                idx = idx - NUM_HARTS;
            end
            if (!win_vld && eligible[idx]) begin
                win_vld = 1'b1;
                win_idx = GW'(idx);
            end
        end
    end

    always_comb begin
        if (int'(grant_q) >= NUM_HARTS - 1) begin
            rot_ptr = '0;
        end else begin
            rot_ptr = grant_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        lat_ren_d   = lat_ren_q;
        lat_wen_d   = lat_wen_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_be_d    = lat_be_q;
        rdata_d     = rdata_q;
`ifdef HART_BUS_LOCK_EN
        lock_cnt_d  = lock_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = BUSY;
                    grant_d     = win_idx;
                    // Read+write together is issued as a write.
                    lat_wen_d   = req_wen[win_idx];
                    lat_ren_d   = req_ren[win_idx] & ~req_wen[win_idx];
                    lat_addr_d  = req_addr[int'(win_idx)*32 +: 32];
                    lat_wdata_d = req_wdata[int'(win_idx)*32 +: 32];
                    lat_be_d    = req_byte_en[int'(win_idx)*4 +: 4];
                end
            end
            BUSY: begin
                if (!bus_busy) begin
                    state_d  = IDLE;
                    rdata_d  = bus_rdata;
`ifdef HART_BUS_LOCK_EN
                    if (req_lock[grant_q] && int'(lock_cnt_q) < LOCK_MAX - 1) begin
                        rr_ptr_d   = grant_q;
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end else begin
                        rr_ptr_d   = rot_ptr;
                        lock_cnt_d = '0;
                    end
`else
                    rr_ptr_d = rot_ptr;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            lat_ren_q   <= 1'b0;
            lat_wen_q   <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
            rdata_q     <= '0;
`ifdef HART_BUS_LOCK_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            lat_ren_q   <= lat_ren_d;
            lat_wen_q   <= lat_wen_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_be_q    <= lat_be_d;
            rdata_q     <= rdata_d;
`ifdef HART_BUS_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    always_comb begin
        req_busy = '1;
        if (done) begin
            req_busy[grant_q] = 1'b0;
        end
    end

    assign req_rdata   = done ? bus_rdata : rdata_q;
    assign bus_ren     = (state_q == BUSY) && lat_ren_q;
    assign bus_wen     = (state_q == BUSY) && lat_wen_q;
    assign bus_addr    = lat_addr_q;
    assign bus_wdata   = lat_wdata_q;
    assign bus_byte_en = lat_be_q;
    assign grant_id    = grant_q;

endmodule
